// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the functional-unit requesters and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] req_op;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   gnt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_y;
    logic [3:0]           rsp_flag;

    modport master (
        output req, req_op, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_y, rsp_flag
    );

    modport slave (
        input  req, req_op, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_y, rsp_flag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one 8-bit ALU among NUM_REQ requesters; one op per grant,
// result returned on a valid/ready channel tagged with the requester id.
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_sel,
    input  logic [7:0]   alu_y,
    input  logic [3:0]   alu_flag,
    output logic         busy
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, pend_q, win_idx, cand;
    logic            win_found, gnt_win, grant;

    // Winner search starts just after the last winner and wraps around.
    always_comb begin : arb_search
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = grant ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants only open while idle or while the held response is being consumed.
    always_comb begin : fsm_out
        gnt_win = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
        grant   = gnt_win && win_found;
        bus.gnt = '0;
        if (grant) bus.gnt = NUM_REQ'(1) << win_idx;
    end

    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            ptr_q         <= ID_W'(NUM_REQ - 1);
            pend_q        <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_y     <= '0;
            bus.rsp_flag  <= '0;
            busy          <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (grant) begin
                alu_sel <= bus.req_op[{win_idx, 2'b00} +: 4];
                alu_a   <= bus.req_a[{win_idx, 3'b000} +: 8];
                alu_b   <= bus.req_b[{win_idx, 3'b000} +: 8];
                pend_q  <= win_idx;
                ptr_q   <= win_idx;
            end
            if (state_q == EXEC) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id    <= pend_q;
                bus.rsp_y     <= alu_y;
                bus.rsp_flag  <= alu_flag;
            end else if ((state_q == RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, response scoreboard, directed scenarios.
module tb_alu_arbiter;
    localparam int unsigned NUM_REQ = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] y;
        logic [3:0] flag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_y;
    logic [3:0] alu_sel, alu_flag;
    logic       busy;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    exp_t       sb[$];

    alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_y    (alu_y),
        .alu_flag (alu_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: flags are {zero, carry, borrow, even-parity}.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       c, bo;
        c  = 1'b0;
        bo = 1'b0;
        s  = '0;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; end
            4'h1: begin y = a - b; bo = (a < b); end
            4'h2: y = a & b;
            4'h3: y = a | b;
            4'h4: y = a ^ b;
            4'hC: y = (a == b) ? 8'h01 : 8'h00;
            default: y = a;
        endcase
        return {y, (y == 8'h00), c, bo, ~^y};
    endfunction

    always_comb {alu_y, alu_flag} = alu_model(alu_sel, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < int'(NUM_REQ); i++) if (v[i] && r < 0) r = i;
        return r;
    endfunction

    // Scoreboard: push on accepted grant, pop on response handshake, flush on reset.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        #2;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'(bus.rsp_id), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_id", 32'(bus.rsp_id), 32'(e.id));
                    check("sb_y", 32'(bus.rsp_y), 32'(e.y));
                    check("sb_flag", 32'(bus.rsp_flag), 32'(e.flag));
                end
            end
            if (bus.gnt != '0) begin
                w = oh_idx(bus.gnt);
                e.id = 2'(w);
                {e.y, e.flag} = alu_model(bus.req_op[w*4 +: 4], bus.req_a[w*8 +: 8],
                                          bus.req_b[w*8 +: 8]);
                sb.push_back(e);
            end
        end
    end

    task automatic set_req(input int idx, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        bus.req[idx]          = 1'b1;
        bus.req_op[idx*4 +: 4] = op;
        bus.req_a[idx*8 +: 8]  = a;
        bus.req_b[idx*8 +: 8]  = b;
    endtask

    // Single uncontended operation from IDLE with rsp_ready high.
    task automatic do_op(input int idx, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ey, input logic [3:0] ef);
        logic [3:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        bus.req = '0;
        set_req(idx, op, a, b);
        #1 check("op_gnt", 32'(bus.gnt), 32'(oh));
        @(negedge clk);
        bus.req = '0;
        #1 check("op_exec_valid", 32'(bus.rsp_valid), 32'd0);
        check("op_exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1 check("op_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("op_rsp_id", 32'(bus.rsp_id), 32'(idx));
        check("op_rsp_y", 32'(bus.rsp_y), 32'(ey));
        check("op_rsp_flag", 32'(bus.rsp_flag), 32'(ef));
        @(negedge clk);
        #1 check("op_idle_busy", 32'(busy), 32'd0);
        check("op_idle_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ids[6];
        int gcyc[6];
        int n;
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_id", 32'(bus.rsp_id), 32'd0);
        check("rst_y", 32'(bus.rsp_y), 32'd0);
        check("rst_flag", 32'(bus.rsp_flag), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt_noreq", 32'(bus.gnt), 32'd0);

        // Add with carry, subtract with borrow, zero/parity, compare-equal.
        do_op(1, 4'h0, 8'hF0, 8'h20, 8'h10, 4'b0100);
        check("alu_hold_a", 32'(alu_a), 32'hF0);
        check("alu_hold_b", 32'(alu_b), 32'h20);
        do_op(0, 4'h1, 8'h05, 8'h07, 8'hFE, 4'b0010);
        do_op(0, 4'h0, 8'h00, 8'h00, 8'h00, 4'b1001);
        do_op(3, 4'hC, 8'h3C, 8'h3C, 8'h01, 4'b0000);

        // All four requesting continuously from a fresh pointer.
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'h0, 8'(8'h10 * i + 1), 8'(i));
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            #1;
            if (bus.gnt != '0) begin
                ids[n]  = oh_idx(bus.gnt);
                gcyc[n] = cyc;
                n++;
            end
            if (n < 6) @(negedge clk);
        end
        @(negedge clk);
        bus.req = '0;
        check("rr_grant_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < n) begin
                check("rr_order", 32'(ids[i]), 32'(i % 4));
                if (i > 0) check("rr_interval", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
            end
        end
        repeat (3) @(negedge clk);
        #1 check("rr_drained_busy", 32'(busy), 32'd0);

        // Backpressure: response held, no grants until consumed, then back-to-back.
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 4'h2, 8'hF0, 8'h3C);
        #1 check("bp_gnt0", 32'(bus.gnt), 32'b0001);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        set_req(2, 4'h4, 8'hAA, 8'h0F);
        #1 check("bp_valid_first", 32'(bus.rsp_valid), 32'd1);
        check("bp_gnt_first", 32'(bus.gnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check("bp_gnt_held", 32'(bus.gnt), 32'd0);
            check("bp_rsp_held", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_flag}),
                  32'({1'b1, 2'd0, 8'h30, 4'b0001}));
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1 check("bp_gnt_release", 32'(bus.gnt), 32'b0100);
        @(negedge clk);
        bus.req = '0;
        #1 check("bp_b2b_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        #1 check("bp_second_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_flag}),
                 32'({1'b1, 2'd2, 8'hA5, 4'b0001}));
        @(negedge clk);

        // Reset during EXEC discards the transaction.
        @(negedge clk);
        set_req(2, 4'h0, 8'h01, 8'h02);
        #1 check("rst_exec_gnt", 32'(bus.gnt), 32'b0100);
        @(negedge clk);
        bus.req = '0;
        rst     = 1'b1;
        #1 check("rst_exec_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_exec_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("rst_exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        set_req(0, 4'h3, 8'h81, 8'h02);
        set_req(2, 4'h1, 8'h10, 8'h01);
        #1 check("post_rst_gnt", 32'(bus.gnt), 32'b0001);
        @(negedge clk);
        bus.req[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && n == 0; c++) begin
            @(negedge clk);
            #1 if (bus.gnt != '0) begin
                n = 1;
                check("post_rst_second_gnt", 32'(bus.gnt), 32'b0100);
            end
        end
        check("post_rst_second_seen", 32'(n), 32'd1);
        @(negedge clk);
        bus.req = '0;
        repeat (4) @(negedge clk);
        #3 check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
